// File: rtl/noc_traffic_gen.sv
// Per-node NoC traffic generator: injects sequence-tagged flits to LFSR-chosen
// destinations and checks ejected flits. Optional macro: TRAFFIC_GEN_RX_STALL_EN.
module noc_traffic_gen #(
    parameter int NUM_OF_NODES            = 8,
    parameter int FLIT_DATA_WIDTH         = 16,
    parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int NODE_ID                 = 0,
    parameter int NUM_OF_PACKETS          = 16,
    parameter int INJECT_INTERVAL         = 4,
    localparam int AW    = $clog2(NUM_OF_NODES),
    localparam int SEQ_W = FLIT_DATA_WIDTH - 2 * AW,
    localparam int VCW   = (NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    output logic [FLIT_DATA_WIDTH-1:0] tx_flit_data,
    output logic [VCW-1:0]             tx_vc,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    input  logic [FLIT_DATA_WIDTH-1:0] rx_flit_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic [SEQ_W-1:0]           tx_count,
    output logic [SEQ_W-1:0]           rx_count,
    output logic [7:0]                 error_count,
    output logic                       error,
    output logic                       done
);

    // state | meaning
    // IDLE  | injection not enabled
    // WAIT  | counting INJECT_INTERVAL idle cycles before next flit
    // SEND  | flit offered, held until tx handshake
    // DONE  | all packets sent; stays here until reset
    typedef enum logic [1:0] {IDLE, WAIT, SEND, DONE} state_t;

    localparam int WCW = (INJECT_INTERVAL > 1) ? $clog2(INJECT_INTERVAL) : 1;
    localparam logic [WCW-1:0]   WAIT_LOAD = WCW'(INJECT_INTERVAL - 1);
    localparam logic [AW-1:0]    NODE_ADDR = AW'(NODE_ID);
    localparam logic [SEQ_W-1:0] LAST_SEQ  = SEQ_W'(NUM_OF_PACKETS - 1);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1 ^ 16'(NODE_ID);

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic [15:0]    lfsr;
    logic [15:0]    lfsr_next;
    logic [AW-1:0]  lfsr_dest;
    logic [AW-1:0]  tx_dest;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign lfsr_dest = lfsr[AW-1:0];
    // Never address ourselves; bump to the neighbour instead.
    assign tx_dest   = (lfsr_dest == NODE_ADDR) ? NODE_ADDR + AW'(1) : lfsr_dest;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            lfsr         <= LFSR_SEED;
            tx_valid     <= 1'b0;
            tx_flit_data <= '0;
            tx_vc        <= '0;
            tx_count     <= '0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                WAIT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (wait_cnt == '0) begin
                        state        <= SEND;
                        tx_valid     <= 1'b1;
                        tx_flit_data <= {tx_dest, NODE_ADDR, tx_count};
                        tx_vc        <= VCW'(tx_count % NUM_OF_VIRTUAL_CHANNELS);
                    end else begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_count <= tx_count + SEQ_W'(1);
                        lfsr     <= lfsr_next;
                        if (tx_count == LAST_SEQ) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (enable) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    tx_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [AW-1:0]    rx_dest;
    logic [AW-1:0]    rx_src;
    logic [SEQ_W-1:0] rx_seq;
    logic [SEQ_W-1:0] exp_seq [NUM_OF_NODES];
    logic             rx_accept;
    logic             rx_mismatch;

    assign rx_dest     = rx_flit_data[FLIT_DATA_WIDTH-1 -: AW];
    assign rx_src      = rx_flit_data[FLIT_DATA_WIDTH-AW-1 -: AW];
    assign rx_seq      = rx_flit_data[SEQ_W-1:0];
    assign rx_accept   = rx_valid & rx_ready;
    assign rx_mismatch = (rx_dest != NODE_ADDR) || (rx_seq != exp_seq[rx_src]);

    // Expected seq always resyncs to the received one so a single loss counts once.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_count    <= '0;
            error_count <= '0;
            error       <= 1'b0;
            for (int i = 0; i < NUM_OF_NODES; i++) begin
                exp_seq[i] <= '0;
            end
        end else if (rx_accept) begin
            rx_count        <= rx_count + SEQ_W'(1);
            exp_seq[rx_src] <= rx_seq + SEQ_W'(1);
            if (rx_mismatch) begin
                error <= 1'b1;
                if (error_count != 8'hFF) begin
                    error_count <= error_count + 8'd1;
                end
            end
        end
    end

`ifdef TRAFFIC_GEN_RX_STALL_EN
    logic [7:0] stall_lfsr;
    logic [7:0] stall_next;

    assign stall_next = {stall_lfsr[6:0],
                         stall_lfsr[7] ^ stall_lfsr[5] ^ stall_lfsr[4] ^ stall_lfsr[3]};

    // rx_ready is registered so it reads 1 in reset regardless of the seed.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_lfsr <= 8'h5A ^ 8'(NODE_ID);
            rx_ready   <= 1'b1;
        end else begin
            stall_lfsr <= stall_next;
            rx_ready   <= ~stall_next[0];
        end
    end
`else
    assign rx_ready = 1'b1;
`endif

endmodule
